// File: rtl/serial_frame_sched_if.sv
// Bundle of the serial frame path: serial input plus lane outputs and status.
// master drives serin and observes the lanes; slave is the scheduler side.
interface serial_frame_sched_if #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4
);
  localparam int NL = 1 << ADDR_W;

  logic              serin;
  logic              busy;
  logic [ADDR_W-1:0] port_sel;
  logic [LEN_W-1:0]  len;
  logic [NL-1:0]     valid;
  logic [NL-1:0]     dout;
  logic              done;

  modport master (
    output serin,
    input  busy, port_sel, len, valid, dout, done
  );

  modport slave (
    input  serin,
    output busy, port_sel, len, valid, dout, done
  );
endinterface

// File: rtl/serial_frame_sched.sv
// Bit-serial frame scheduler: start bit, MSB-first lane address and payload length,
// then payload bits routed to one of 2^ADDR_W lanes, followed by a one-cycle done.
module serial_frame_sched #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  serial_frame_sched_if.slave bus
);
  localparam int NL    = 1 << ADDR_W;
  localparam int CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] port_sel_q, port_sel_d;
  logic [LEN_W-1:0]  len_q, len_d, len_shift;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NL-1:0]     valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_sel_d = port_sel_q;
    len_d      = len_q;
    len_shift  = LEN_W'({len_q, bus.serin});
    case (state_q)
      IDLE: begin
        if (!bus.serin) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        port_sel_d = ADDR_W'({port_sel_q, bus.serin});
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          state_d = LEN;
          cnt_d   = '0;
        end
      end
      LEN: begin
        len_d = len_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LEN_W - 1)) begin
          cnt_d   = '0;
          state_d = (len_shift == '0) ? DONE : DATA;
        end
      end
      DATA: begin
        // len_q is nonzero here, so cnt_q tops out at len_q-1 and never wraps.
        cnt_d = cnt_q + CNT_W'(1);
        if ((cnt_q + CNT_W'(1)) == CNT_W'(len_q)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == DATA) ? (NL'(1) << port_sel_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_sel_q <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_sel_q <= port_sel_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;
  assign bus.port_sel = port_sel_q;
  assign bus.len      = len_q;
  assign bus.dout     = valid_q & {NL{bus.serin}};
endmodule

// File: tb/tb_serial_frame_sched.sv
// Bench for serial_frame_sched: bit streams are parsed by a frame-level model
// to predict per-cycle lane outputs, then compared against the captured DUT outputs.
module tb_serial_frame_sched;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 4;
  localparam int NL     = 1 << ADDR_W;
  localparam int OW     = 2 * NL + 2;
  localparam int PW     = ADDR_W + LEN_W;
  localparam int MAXS   = 1024;
  localparam logic [NL-1:0] ZL = '0;

  logic clk = 1'b0;
  logic reset;

  serial_frame_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
  serial_frame_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic          stim    [MAXS];
  int            n_stim;
  logic [OW-1:0] obs_out [MAXS];
  logic [OW-1:0] exp_out [MAXS];
  logic [PW-1:0] obs_pl  [MAXS];
  logic [PW-1:0] exp_pl  [MAXS];
  bit            exp_chk [MAXS];
  logic [ADDR_W-1:0] m_psel;
  logic [LEN_W-1:0]  m_len;

  task automatic push_bit(input logic b);
    stim[n_stim] = b;
    n_stim++;
  endtask

  // Frame = start 0, address MSB-first, length MSB-first, payload bits data[0..l-1],
  // then the bit presented during the DONE cycle, then gap idle ones.
  task automatic push_frame(input int addr, input int l, input logic [15:0] data,
                            input logic done_bit, input int gap);
    push_bit(1'b0);
    for (int i = ADDR_W - 1; i >= 0; i--) push_bit(((addr >> i) & 1) != 0);
    for (int i = LEN_W - 1; i >= 0; i--) push_bit(((l >> i) & 1) != 0);
    for (int i = 0; i < l; i++) push_bit(data[i]);
    push_bit(done_bit);
    for (int i = 0; i < gap; i++) push_bit(1'b1);
  endtask

  // Frame-level reference: cycle k is the cycle in which stim[k] is on serin.
  function automatic void run_model();
    int k, s, a, l, c, d;
    logic [NL-1:0] oh;
    for (int i = 0; i < MAXS; i++) exp_chk[i] = 1'b0;
    k = 0;
    while (k < n_stim) begin
      exp_out[k] = '0;
      exp_pl[k]  = {m_psel, m_len};
      exp_chk[k] = 1'b1;
      if (stim[k] === 1'b0) begin
        s = k;
        a = 0;
        l = 0;
        for (int i = 1; i <= ADDR_W; i++) a = (a << 1) | int'(stim[s + i]);
        for (int i = 1; i <= LEN_W; i++) l = (l << 1) | int'(stim[s + ADDR_W + i]);
        for (int i = s + 1; i <= s + ADDR_W + LEN_W; i++) begin
          exp_out[i] = {1'b1, ZL, 1'b0, ZL};
          exp_chk[i] = 1'b0;
        end
        m_psel = ADDR_W'(a);
        m_len  = LEN_W'(l);
        oh     = NL'(1) << a;
        for (int i = 0; i < l; i++) begin
          c = s + ADDR_W + LEN_W + 1 + i;
          exp_out[c] = {1'b1, oh, 1'b0, stim[c] ? oh : ZL};
          exp_pl[c]  = {m_psel, m_len};
          exp_chk[c] = 1'b1;
        end
        d = s + ADDR_W + LEN_W + 1 + l;
        exp_out[d] = {1'b1, ZL, 1'b1, ZL};
        exp_pl[d]  = {m_psel, m_len};
        exp_chk[d] = 1'b1;
        k = d + 1;
      end else begin
        k++;
      end
    end
  endfunction

  task automatic drive_stream(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.serin = stim[k];
      #1;
      obs_out[k] = {bus.busy, bus.valid, bus.done, bus.dout};
      obs_pl[k]  = {bus.port_sel, bus.len};
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.serin = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.valid, bus.done, bus.dout} !== {1'b0, ZL, 1'b0, ZL}) begin
      n_bad++;
      $display("FAIL reset_out: got %b want %b", {bus.busy, bus.valid, bus.done, bus.dout},
               {1'b0, ZL, 1'b0, ZL});
    end
    n_cmp++;
    if ({bus.port_sel, bus.len} !== {PW{1'b0}}) begin
      n_bad++;
      $display("FAIL reset_fields: got %b want %b", {bus.port_sel, bus.len}, {PW{1'b0}});
    end
    reset  = 1'b1;
    m_psel = '0;
    m_len  = '0;
  endtask

  task automatic test_idle();
    n_stim = 0;
    for (int i = 0; i < 10; i++) push_bit(1'b1);
    run_model();
    drive_stream(n_stim);
    for (int k = 0; k < n_stim; k++) begin
      n_cmp++;
      if (obs_out[k] !== exp_out[k]) begin
        n_bad++;
        $display("FAIL idle_out cyc %0d: got %b want %b", k, obs_out[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_frame();
    int nv, nd;
    n_stim = 0;
    push_frame(2, 3, 16'h0005, 1'b1, 3);
    run_model();
    drive_stream(n_stim);
    nv = 0;
    nd = 0;
    for (int k = 0; k < n_stim; k++) begin
      n_cmp++;
      if (obs_out[k] !== exp_out[k]) begin
        n_bad++;
        $display("FAIL frame_out cyc %0d: got %b want %b", k, obs_out[k], exp_out[k]);
      end
      if (exp_chk[k]) begin
        n_cmp++;
        if (obs_pl[k] !== exp_pl[k]) begin
          n_bad++;
          $display("FAIL frame_sel_len cyc %0d: got %b want %b", k, obs_pl[k], exp_pl[k]);
        end
      end
      if (obs_out[k][NL+NL:NL+1] === 4'b0100) nv++;
      if (obs_out[k][NL] === 1'b1) nd++;
    end
    n_cmp++;
    if (nv != 3 || nd != 1) begin
      n_bad++;
      $display("FAIL frame_counts: valid cycles %0d done pulses %0d, want 3 and 1", nv, nd);
    end
  endtask

  task automatic test_zero_len();
    n_stim = 0;
    push_frame(3, 0, 16'h0000, 1'b1, 3);
    run_model();
    drive_stream(n_stim);
    for (int k = 0; k < n_stim; k++) begin
      n_cmp++;
      if (obs_out[k] !== exp_out[k]) begin
        n_bad++;
        $display("FAIL zero_len_out cyc %0d: got %b want %b", k, obs_out[k], exp_out[k]);
      end
      if (exp_chk[k]) begin
        n_cmp++;
        if (obs_pl[k] !== exp_pl[k]) begin
          n_bad++;
          $display("FAIL zero_len_sel_len cyc %0d: got %b want %b", k, obs_pl[k], exp_pl[k]);
        end
      end
    end
  endtask

  task automatic test_max_len();
    int nv;
    n_stim = 0;
    push_frame(0, 15, 16'h5555, 1'b1, 3);
    run_model();
    drive_stream(n_stim);
    nv = 0;
    for (int k = 0; k < n_stim; k++) begin
      n_cmp++;
      if (obs_out[k] !== exp_out[k]) begin
        n_bad++;
        $display("FAIL max_len_out cyc %0d: got %b want %b", k, obs_out[k], exp_out[k]);
      end
      if (obs_out[k][NL+1] === 1'b1) nv++;
    end
    n_cmp++;
    if (nv != 15) begin
      n_bad++;
      $display("FAIL max_len_valid_cycles: got %0d want 15", nv);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    n_stim = 0;
    push_frame(1, 2, 16'h0003, 1'b0, 0);
    push_frame(2, 1, 16'h0000, 1'b1, 3);
    run_model();
    drive_stream(n_stim);
    nd = 0;
    for (int k = 0; k < n_stim; k++) begin
      n_cmp++;
      if (obs_out[k] !== exp_out[k]) begin
        n_bad++;
        $display("FAIL b2b_out cyc %0d: got %b want %b", k, obs_out[k], exp_out[k]);
      end
      if (exp_chk[k]) begin
        n_cmp++;
        if (obs_pl[k] !== exp_pl[k]) begin
          n_bad++;
          $display("FAIL b2b_sel_len cyc %0d: got %b want %b", k, obs_pl[k], exp_pl[k]);
        end
      end
      if (obs_out[k][NL] === 1'b1) nd++;
    end
    n_cmp++;
    if (nd != 2) begin
      n_bad++;
      $display("FAIL b2b_done_pulses: got %0d want 2", nd);
    end
  endtask

  task automatic test_reset_mid();
    logic [NL-1:0] dexp;
    n_stim = 0;
    push_frame(1, 5, 16'h0015, 1'b1, 3);
    drive_stream(9);
    dexp = stim[8] ? 4'b0010 : 4'b0000;
    n_cmp++;
    if (obs_out[8] !== {1'b1, 4'b0010, 1'b0, dexp}) begin
      n_bad++;
      $display("FAIL reset_mid_pre cyc 8: got %b want %b", obs_out[8], {1'b1, 4'b0010, 1'b0, dexp});
    end
    @(negedge clk);
    bus.serin = 1'b1;
    reset     = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.valid, bus.done, bus.dout, bus.port_sel, bus.len} !== {OW+PW{1'b0}}) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %b want all zero",
               {bus.busy, bus.valid, bus.done, bus.dout, bus.port_sel, bus.len});
    end
    @(negedge clk);
    reset  = 1'b1;
    m_psel = '0;
    m_len  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.valid, bus.done} !== {1'b0, ZL, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_mid_idle cyc %0d: got %b want %b", i,
                 {bus.busy, bus.valid, bus.done}, {1'b0, ZL, 1'b0});
      end
    end
  endtask

  task automatic test_random();
    n_stim = 0;
    for (int f = 0; f < 12; f++) begin
      push_frame(int'($urandom_range(0, NL - 1)), int'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 4; i++) push_bit(1'b1);
    run_model();
    drive_stream(n_stim);
    for (int k = 0; k < n_stim; k++) begin
      n_cmp++;
      if (obs_out[k] !== exp_out[k]) begin
        n_bad++;
        $display("FAIL random_out cyc %0d: got %b want %b", k, obs_out[k], exp_out[k]);
      end
      if (exp_chk[k]) begin
        n_cmp++;
        if (obs_pl[k] !== exp_pl[k]) begin
          n_bad++;
          $display("FAIL random_sel_len cyc %0d: got %b want %b", k, obs_pl[k], exp_pl[k]);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    bus.serin = 1'b1;
    test_reset();
    test_idle();
    test_frame();
    test_zero_len();
    test_max_len();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
